// File: rtl/pi_error_frontend.sv
// pi_error_frontend: converts offset-binary ADC samples to a signed measurement,
// ramps the setpoint toward a loaded target at a bounded rate, and registers the
// saturated error (sp - meas) and anti-windup (u_sat - u) words for the PI block.
// A run of out-of-range errors trips a sticky FAULT that is cleared by disabling.
//
// Handshake: i_ADC_valid is a single-cycle strobe with no back-pressure. Each
// strobe that is processed in RAMP/TRACK without tripping produces exactly one
// o_valid pulse on the following cycle, together with new o_err/o_aw.
module pi_error_frontend #(
   parameter int N_ADC     = 14,
   parameter int OFFSET    = 8192,
   parameter int RAMP_STEP = 16,
   parameter int ERR_LIMIT = 1048576,
   parameter int FAULT_CNT = 4
) (
   input  logic                i_CLK,
   input  logic                i_RST,
   input  logic [N_ADC-1:0]    i_ADC,
   input  logic                i_ADC_valid,
   input  logic signed [31:0]  i_SP,
   input  logic                i_SP_load,
   input  logic                i_enable,
   input  logic signed [31:0]  i_u,
   input  logic signed [31:0]  i_u_sat,
   output logic signed [31:0]  o_err,
   output logic signed [31:0]  o_aw,
   output logic                o_valid,
   output logic signed [31:0]  o_sp,
   output logic [1:0]          o_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RAMP  = 2'd1,
      S_TRACK = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   localparam logic signed [32:0] L_STEP33 = 33'(RAMP_STEP);
   localparam logic signed [31:0] L_STEP32 = 32'(RAMP_STEP);
   localparam logic signed [32:0] L_LIM33  = 33'(ERR_LIMIT);
   localparam logic [3:0]         L_FCNT   = 4'(FAULT_CNT);

   state_t             r_state, w_state_nxt;
   logic signed [31:0] r_tgt, r_sp, r_err, r_aw;
   logic               r_valid;
   logic [3:0]         r_cnt;

   logic signed [31:0] w_sp_nxt, w_err_nxt, w_aw_nxt;
   logic               w_valid_nxt;
   logic [3:0]         w_cnt_nxt;

   logic signed [31:0] w_meas, w_tgt, w_sp_step;
   logic signed [32:0] w_diff, w_err33, w_aw33;
   logic               w_near, w_oor, w_trip;
   logic [3:0]         w_cnt_inc;

   // Clamp a 33-bit result into int32; overflow shows as bits 32 and 31 differing.
   function automatic logic signed [31:0] sat33(input logic signed [32:0] x);
      if (x[32] != x[31]) return x[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
      return x[31:0];
   endfunction

   // A load in the same cycle as a sample takes effect for that sample.
   assign w_tgt     = i_SP_load ? i_SP : r_tgt;
   assign w_meas    = $signed({{(32-N_ADC){1'b0}}, i_ADC}) - OFFSET;
   assign w_diff    = $signed({w_tgt[31], w_tgt}) - $signed({r_sp[31], r_sp});
   assign w_near    = (w_diff <= L_STEP33) && (w_diff >= -L_STEP33);
   // Stepping only happens when |diff| > step, so the result stays in int32.
   assign w_sp_step = w_near ? w_tgt : (w_diff[32] ? r_sp - L_STEP32 : r_sp + L_STEP32);
   assign w_err33   = $signed({w_sp_step[31], w_sp_step}) - $signed({w_meas[31], w_meas});
   assign w_aw33    = $signed({i_u_sat[31], i_u_sat}) - $signed({i_u[31], i_u});
   assign w_oor     = (w_err33 > L_LIM33) || (w_err33 < -L_LIM33);
   assign w_cnt_inc = r_cnt + 4'd1;
   assign w_trip    = w_oor && (w_cnt_inc == L_FCNT);

   // State register.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic; disable always wins, a trip wins over reaching the target.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_enable) w_state_nxt = S_RAMP;
         S_RAMP: begin
            if (!i_enable)        w_state_nxt = S_IDLE;
            else if (i_ADC_valid) begin
               if (w_trip)        w_state_nxt = S_FAULT;
               else if (w_near)   w_state_nxt = S_TRACK;
            end
         end
         S_TRACK: begin
            if (!i_enable)        w_state_nxt = S_IDLE;
            else if (i_ADC_valid) begin
               if (w_trip)        w_state_nxt = S_FAULT;
               else if (!w_near)  w_state_nxt = S_RAMP;
            end
            else if (i_SP_load && (i_SP != r_sp)) w_state_nxt = S_RAMP;
         end
         S_FAULT: if (!i_enable) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output/datapath next values for setpoint, error words, strobe and fault counter.
   always_comb begin
      w_sp_nxt    = r_sp;
      w_err_nxt   = r_err;
      w_aw_nxt    = r_aw;
      w_valid_nxt = 1'b0;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_RAMP, S_TRACK: begin
            if (!i_enable) begin
               w_err_nxt = '0;
               w_aw_nxt  = '0;
               w_cnt_nxt = '0;
               if (i_ADC_valid) w_sp_nxt = w_meas;
            end
            else if (i_ADC_valid) begin
               w_sp_nxt = w_sp_step;
               if (w_trip) begin
                  w_err_nxt = '0;
                  w_aw_nxt  = '0;
                  w_cnt_nxt = w_cnt_inc;
               end
               else begin
                  w_err_nxt   = sat33(w_err33);
                  w_aw_nxt    = sat33(w_aw33);
                  w_valid_nxt = 1'b1;
                  w_cnt_nxt   = w_oor ? w_cnt_inc : 4'd0;
               end
            end
         end
         S_FAULT: begin
            w_err_nxt = '0;
            w_aw_nxt  = '0;
            if (!i_enable) w_cnt_nxt = '0;
         end
         default: begin
            // IDLE: bumpless tracking of the measurement.
            w_err_nxt = '0;
            w_aw_nxt  = '0;
            w_cnt_nxt = '0;
            if (i_ADC_valid) w_sp_nxt = w_meas;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         r_tgt   <= '0;
         r_sp    <= '0;
         r_err   <= '0;
         r_aw    <= '0;
         r_valid <= 1'b0;
         r_cnt   <= '0;
      end
      else begin
         if (i_SP_load) r_tgt <= i_SP;
         r_sp    <= w_sp_nxt;
         r_err   <= w_err_nxt;
         r_aw    <= w_aw_nxt;
         r_valid <= w_valid_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign o_err   = r_err;
   assign o_aw    = r_aw;
   assign o_valid = r_valid;
   assign o_sp    = r_sp;
   assign o_state = r_state;

endmodule

// File: doc/pi_error_frontend.md
Name: pi_error_frontend

Overview:
- Front end that feeds the PI controller: converts raw ADC samples to a signed measurement, generates a rate-limited (ramped) setpoint, and produces registered error and anti-windup feedback words.
- Sits between the ADC interface and the PI block's err/aw inputs.
- Closes the loop from the controller's unsaturated and saturated outputs back to the aw input.
- Provides bumpless enable and an error-limit fault trip.

Parameters:
- N_ADC, 14, ADC sample width, offset-binary.
- OFFSET, 8192, ADC code subtracted to obtain the signed measurement.
- RAMP_STEP, 16, maximum setpoint change per valid sample; must be > 0.
- ERR_LIMIT, 1048576, magnitude above which an error sample counts as out of range.
- FAULT_CNT, 4, consecutive out-of-range samples needed to trip FAULT; range 1..15.

Ports:
- i_CLK, in, 1, system clock; all state updates on the rising edge.
- i_RST, in, 1, asynchronous active-high reset.
- i_ADC, in, N_ADC, offset-binary measurement.
- i_ADC_valid, in, 1, single-cycle sample strobe.
- i_SP, in, 32, signed target setpoint.
- i_SP_load, in, 1, captures i_SP as the new target.
- i_enable, in, 1, loop enable (level).
- i_u, in, 32, signed PI output before saturation.
- i_u_sat, in, 32, signed PI output after saturation.
- o_err, out, 32, signed error = sp − meas, registered.
- o_aw, out, 32, signed anti-windup term = i_u_sat − i_u, registered.
- o_valid, out, 1, one-cycle pulse marking new o_err/o_aw.
- o_sp, out, 32, current ramped setpoint.
- o_state, out, 2, FSM state: IDLE=0, RAMP=1, TRACK=2, FAULT=3.

Behaviour:
- Reset (async, i_RST=1):
  - state=IDLE.
  - o_err=0, o_aw=0, o_valid=0, o_sp=0.
  - Target register=0, fault counter=0.
- Measurement:
  - meas = zero-extended i_ADC minus OFFSET, signed 32-bit.
  - meas is computed combinationally, using only the sample present when i_ADC_valid=1.
- Arithmetic rules:
  - err and aw are computed at 33 bits and saturated to the int32 range [−2^31, 2^31−1] before registering.
  - No wrap-around is permitted.
- Latency: i_ADC_valid high in cycle k → o_err, o_aw, o_valid updated in cycle k+1. o_valid is high for exactly one cycle per sample.
- Target:
  - i_SP_load=1 captures i_SP in any state.
  - If i_SP_load and i_ADC_valid coincide, the new target is used for that sample's ramp step.
- IDLE:
  - On each valid sample, o_sp <= meas (bumpless tracking).
  - o_err=0, o_aw=0, o_valid=0.
  - i_enable=1 → RAMP on the next clock.
- RAMP (updates only on valid samples):
  - If |target − sp| <= RAMP_STEP: sp <= target and the state moves to TRACK.
  - Otherwise sp moves toward target by exactly RAMP_STEP.
  - err uses the updated sp.
- TRACK:
  - sp = target.
  - A load with target ≠ sp → RAMP; the step is applied on the next valid sample.
  - A load with target equal to sp stays in TRACK.
- Fault counting (RAMP and TRACK only, per valid sample):
  - |err| > ERR_LIMIT increments the fault counter.
  - An in-range sample clears the counter.
  - The counter reaching FAULT_CNT → FAULT. That sample's o_err and o_aw are forced to 0 and o_valid is not pulsed.
- FAULT:
  - o_err=0, o_aw=0, o_valid=0, o_sp held.
  - Sticky; exits only when i_enable=0 → IDLE, which also clears the counter.
- i_enable=0 in RAMP or TRACK:
  - → IDLE on the next clock; o_err and o_aw are cleared the same edge.
  - A valid sample in that same cycle is processed as IDLE (sp tracks meas, no o_valid).
- Reset mid-ramp: immediate return to reset values; the ramp is not resumed.

Test Plan:
- Reset and bumpless start: reset, i_enable=0, ADC=8292 valid → o_sp=100, o_valid stays 0, o_state=0. Then i_enable=1, load i_SP=100, one sample → o_state goes 1 then 2; o_err=0.
- Ramp: sp=0, i_SP=50 loaded, RAMP_STEP=16, ADC=8192 per sample → o_sp = 16, 32, 48, 50. o_err = 16, 32, 48, 50. The state becomes TRACK on the fourth sample. o_valid pulses once per sample, one cycle after each strobe.
- Anti-windup: i_u=1200, i_u_sat=1000 → o_aw=−200. i_u=−2^31, i_u_sat=2^31−1 → o_aw=2^31−1 (saturated).
- Fault: err of 2,000,000 on 3 samples, then 1 in-range sample, then 4 out-of-range samples → no trip until the 4th of the final run. Then o_state=3, o_valid=0; i_enable=0 → o_state=0.
- Simultaneous events: i_SP_load (target=−40) and i_ADC_valid in the same cycle while in TRACK at sp=0 → the step is taken toward −40, o_sp=−16, state RAMP.
- Asynchronous reset asserted mid-cycle during RAMP → outputs zero before the next clock edge; after release, o_state=0.
